pix_mem_arb: RTL and testbench
==============================

PIX_MEM_ARB -- requirements
Module: pix_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, meaning the pixel memory address width.
REQ-002 SHALL have parameter FRAME_PIX, default 307200, meaning pixels per frame (640x480).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning write FIFO entries (power of 2).
REQ-004 SHALL have port clk  in  1  system clock.
REQ-005 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port sync_vsync  in  1  display frame restart; clears read address.
REQ-007 SHALL have port rd_req  in  1  display pixel read request (VGA ReadMem).
REQ-008 SHALL have port rd_data  out  12  display pixel ({B,G,R} 4:4:4) to VGA ROWdata.
REQ-009 SHALL have port wr_valid  in  1  writer pixel valid.
REQ-010 SHALL have port wr_ready  out  1  writer pixel accepted when high with wr_valid.
REQ-011 SHALL have port wr_data  in  12  writer pixel.
REQ-012 SHALL have port wr_sof  in  1  writer start-of-frame, qualified by wr_valid.
REQ-013 SHALL have port mem_en  out  1  memory access strobe.
REQ-014 SHALL have port mem_we  out  1  memory write enable.
REQ-015 SHALL have port mem_addr  out  ADDR_W  memory address.
REQ-016 SHALL have port mem_wdata  out  12  memory write data.
REQ-017 SHALL have port mem_rdata  in  12  memory read data, valid one cycle after a read strobe.
REQ-018 SHALL have port fifo_full_seen  out  1  sticky flag, FIFO reached full this frame.

Function
REQ-019 Single-port memory; exactly one access per cycle; read has absolute priority.
REQ-020 Cycle with rd_req=1: mem_en=1, mem_we=0, mem_addr=rd_addr (combinational); no write issued.
REQ-021 rd_data SHALL equal mem_rdata; read latency exactly 1 cycle from rd_req to rd_data.
REQ-022 rd_addr increments per rd_req cycle; wraps FRAME_PIX-1 -> 0.
REQ-023 sync_vsync=1 forces the cycle's read address to 0 and next rd_addr to 1 if rd_req, else 0.
REQ-024 Writer pixels enter a FIFO of {wr_sof, wr_data}; push when wr_valid && wr_ready; wr_ready = !full.
REQ-025 Cycle with rd_req=0 and FIFO non-empty: pop head, mem_en=1, mem_we=1, mem_wdata=head data, mem_addr=head sof ? 0 : wr_addr.
REQ-026 After each issued write, wr_addr = issued address + 1, wrapping FRAME_PIX-1 -> 0.
REQ-027 No bypass: a pushed pixel reaches memory no earlier than the next cycle.
REQ-028 Push and pop in the same cycle SHALL leave occupancy unchanged, including at empty-1 and full-1 boundaries.
REQ-029 Idle cycle (no rd_req, FIFO empty): mem_en=0, mem_we=0, mem_addr=0.
REQ-030 fifo_full_seen sets when FIFO full; clears on sync_vsync, unless full in that same cycle.

Reset
REQ-031 Reset SHALL clear rd_addr, wr_addr, FIFO pointers/occupancy, and fifo_full_seen.
REQ-032 During reset: wr_ready=1, mem_en=0, mem_we=0; mem_addr=0.
REQ-033 FIFO contents at reset are discarded; a reset mid-frame SHALL not issue a partial write.

Structure
REQ-034 A shared package pix_pkg SHALL define PIX_W=12, FRAME_PIX, ADDR_W, and the {sof,data} FIFO entry type.
REQ-035 FIFO SHALL be a sub-module pix_wr_fifo (sync, first-word-fall-through, full/empty flags); arbitration and address counters stay in pix_mem_arb.

Verification
REQ-036 Reset, then idle -> mem_en=0, wr_ready=1, fifo_full_seen=0, rd_addr=0.
REQ-037 Push 4 pixels 0x111..0x444 with wr_sof on first, rd_req=0 -> writes to addr 0..3 on 4 consecutive cycles starting 1 cycle after first push.
REQ-038 Run 640 rd_req cycles while pushing 20 pixels -> no write during rd_req, wr_ready=0 after 16 held, fifo_full_seen=1; rd_data = preloaded memory value 1 cycle later.
REQ-039 rd_req held for FRAME_PIX+2 cycles -> addresses 0..FRAME_PIX-1, 0, 1 (wrap).
REQ-040 sync_vsync with rd_req at rd_addr=1000 -> that read uses addr 0, next read uses addr 1; fifo_full_seen cleared.
REQ-041 Assert rstn low with 8 FIFO entries pending -> no mem_we after reset; next sof pixel writes addr 0.

Source files
------------

// File: rtl/pix_pkg.sv
// Shared pixel-memory types and defaults.
// The FIFO entry pairs a 4:4:4 pixel with its start-of-frame marker.
package pix_pkg;

    localparam int PIX_W     = 12;
    localparam int FRAME_PIX = 307200;
    localparam int ADDR_W    = 19;

    typedef struct packed {
        logic             sof;
        logic [PIX_W-1:0] data;
    } pix_entry_t;

    localparam int ENTRY_W = $bits(pix_entry_t);

endpackage

// File: rtl/pix_wr_fifo.sv
// Synchronous first-word-fall-through FIFO for writer pixels.
// Head entry is always visible on dout while not empty.
module pix_wr_fifo #(
    parameter int W     = 13,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            // simultaneous push and pop leaves occupancy unchanged
            if (do_push && !do_pop)
                cnt <= cnt + 1'b1;
            else if (do_pop && !do_push)
                cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/pix_mem_arb.sv
// Single-port pixel memory arbiter: display reads win every cycle,
// buffered writer pixels drain through the FIFO when the port is free.
module pix_mem_arb #(
    parameter int ADDR_W     = 19,
    parameter int FRAME_PIX  = 307200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              sync_vsync,
    input  logic              rd_req,
    output logic [11:0]       rd_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [11:0]       wr_data,
    input  logic              wr_sof,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [11:0]       mem_wdata,
    input  logic [11:0]       mem_rdata,
    output logic              fifo_full_seen
);

    import pix_pkg::*;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_PIX - 1);

    pix_entry_t        din;
    pix_entry_t        head;
    logic              full;
    logic              empty;
    logic              pop;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_cur;
    logic [ADDR_W-1:0] wr_cur;

    function automatic logic [ADDR_W-1:0] nxt(input logic [ADDR_W-1:0] a);
        return (a == LAST) ? '0 : a + 1'b1;
    endfunction

    assign din      = '{sof: wr_sof, data: wr_data};
    assign wr_ready = !full;
    assign rd_data  = mem_rdata;
    assign pop      = !rd_req && !empty;
    assign rd_cur   = sync_vsync ? '0 : rd_addr;
    assign wr_cur   = head.sof ? '0 : wr_addr;

    pix_wr_fifo #(
        .W     (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (wr_valid),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // port stays quiet while reset is asserted, even if rd_req is high
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rstn) begin
            if (rd_req) begin
                mem_en   = 1'b1;
                mem_addr = rd_cur;
            end else if (!empty) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wr_cur;
                mem_wdata = head.data;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_addr        <= '0;
            wr_addr        <= '0;
            fifo_full_seen <= 1'b0;
        end else begin
            if (rd_req)
                rd_addr <= nxt(rd_cur);
            else if (sync_vsync)
                rd_addr <= '0;
            if (pop)
                wr_addr <= nxt(wr_cur);
            if (full)
                fifo_full_seen <= 1'b1;
            else if (sync_vsync)
                fifo_full_seen <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pix_mem_arb.sv
// Directed bench for pix_mem_arb with a small frame and a
// behavioural single-port memory model.
module tb_pix_mem_arb;

    localparam int AW = 11;
    localparam int FP = 1100;

    logic          clk = 1'b0;
    logic          rstn;
    logic          sync_vsync;
    logic          rd_req;
    logic [11:0]   rd_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [11:0]   wr_data;
    logic          wr_sof;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [11:0]   mem_wdata;
    logic [11:0]   mem_rdata;
    logic          fifo_full_seen;
    logic          pre_fill;

    logic [11:0] ram [2048];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pix_mem_arb #(
        .ADDR_W     (AW),
        .FRAME_PIX  (FP),
        .FIFO_DEPTH (16)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .sync_vsync     (sync_vsync),
        .rd_req         (rd_req),
        .rd_data        (rd_data),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_data        (wr_data),
        .wr_sof         (wr_sof),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .fifo_full_seen (fifo_full_seen)
    );

    function automatic logic [11:0] pat(input int i);
        return 12'(i * 7 + 3);
    endfunction

    always @(posedge clk) begin
        if (pre_fill) begin
            for (int i = 0; i < 2048; i++) ram[i] <= pat(i);
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int k, wn, nb, nb2, nb3, a;
        logic [11:0] px [4];
        px[0] = 12'h111; px[1] = 12'h222;
        px[2] = 12'h333; px[3] = 12'h444;

        rstn = 1'b0; sync_vsync = 1'b0; rd_req = 1'b0;
        wr_valid = 1'b0; wr_data = '0; wr_sof = 1'b0; pre_fill = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_en", mem_en, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_rdy", wr_ready, 1);
        step();
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_en", mem_en, 0);
        chk("idle_rdy", wr_ready, 1);
        chk("idle_seen", fifo_full_seen, 0);
        chk("idle_addr", mem_addr, 0);
        step();
        rd_req = 1'b1;
        @(negedge clk);
        chk("rd0_addr", mem_addr, 0);
        chk("rd0_we", mem_we, 0);
        chk("rd0_en", mem_en, 1);
        step();
        rd_req = 1'b0;

        // four pixels, sof on the first, no reads
        for (int c = 0; c < 6; c++) begin
            wr_valid = (c < 4);
            wr_sof   = (c == 0);
            wr_data  = (c < 4) ? px[c] : 12'h0;
            @(negedge clk);
            if (c == 0) begin
                chk("w_nobypass", mem_en, 0);
            end else if (c <= 4) begin
                chk($sformatf("w_we%0d", c), mem_we, 1);
                chk($sformatf("w_addr%0d", c), mem_addr, c - 1);
                chk($sformatf("w_data%0d", c), mem_wdata, px[c-1]);
            end else begin
                chk("w_idle", mem_en, 0);
            end
            step();
        end
        wr_valid = 1'b0;
        wr_sof   = 1'b0;
        pre_fill = 1'b1;
        step();
        pre_fill = 1'b0;

        // 640 reads while the writer tries 20 pixels
        k = 0; nb = 0; nb2 = 0; nb3 = 0;
        for (int c = 0; c < 640; c++) begin
            rd_req     = 1'b1;
            sync_vsync = (c == 0);
            wr_valid   = (k < 20);
            wr_data    = 12'h500 + 12'(k);
            @(negedge clk);
            if (mem_we) nb++;
            if (mem_addr != AW'(c)) nb2++;
            if (c > 0 && rd_data != pat(c - 1)) nb3++;
            if (c == 15) chk("rdy15", wr_ready, 1);
            if (c == 16) chk("full16", wr_ready, 0);
            if (c == 17) chk("seen17", fifo_full_seen, 1);
            if (wr_valid && wr_ready) k++;
            step();
        end
        sync_vsync = 1'b0;
        chk("rd_no_we", nb, 0);
        chk("rd_addr_seq", nb2, 0);
        chk("rd_data_seq", nb3, 0);
        chk("accepted16", k, 16);

        rd_req = 1'b0;
        wn = 0; nb = 0;
        for (int c = 0; c < 60; c++) begin
            wr_valid = (k < 20);
            wr_data  = 12'h500 + 12'(k);
            @(negedge clk);
            if (c == 0) chk("rd_last", rd_data, pat(639));
            if (mem_we) begin
                if (mem_addr != AW'(4 + wn) || mem_wdata != 12'h500 + 12'(wn))
                    nb++;
                wn++;
            end
            if (wr_valid && wr_ready) k++;
            step();
        end
        wr_valid = 1'b0;
        chk("drain_cnt", wn, 20);
        chk("drain_seq", nb, 0);

        // frame wrap
        nb = 0;
        for (int c = 0; c < FP + 2; c++) begin
            rd_req     = 1'b1;
            sync_vsync = (c == 0);
            @(negedge clk);
            if (mem_addr != AW'((c < FP) ? c : c - FP)) nb++;
            if (c == 1)  chk("seen_clr", fifo_full_seen, 0);
            if (c == FP) chk("wrap0", mem_addr, 0);
            step();
        end
        sync_vsync = 1'b0;
        chk("wrap_seq", nb, 0);

        // climb to rd_addr 1000 with a full FIFO drained mid-way
        a = 0; wn = 0; nb = 0; nb2 = 0;
        for (int c = 0; c < 1020; c++) begin
            rd_req     = !(c >= 500 && c < 520);
            sync_vsync = (c == 0);
            wr_valid   = (c < 16);
            wr_data    = 12'h600 + 12'(c);
            @(negedge clk);
            if (rd_req) begin
                if (mem_addr != AW'(a)) nb++;
                a++;
            end else if (mem_we) begin
                if (mem_addr != AW'(24 + wn)) nb2++;
                wn++;
            end
            if (c == 519) chk("sticky", fifo_full_seen, 1);
            step();
        end
        wr_valid = 1'b0;
        chk("to1000_seq", nb, 0);
        chk("mid_drain_cnt", wn, 16);
        chk("mid_drain_addr", nb2, 0);
        rd_req = 1'b1;
        sync_vsync = 1'b1;
        @(negedge clk);
        chk("vs_addr", mem_addr, 0);
        chk("vs_seen_pre", fifo_full_seen, 1);
        step();
        sync_vsync = 1'b0;
        @(negedge clk);
        chk("vs_next", mem_addr, 1);
        chk("vs_seen_clr", fifo_full_seen, 0);
        step();

        // vsync in a cycle where the FIFO is full keeps the flag
        for (int c = 0; c < 17; c++) begin
            wr_valid   = (c < 16);
            sync_vsync = (c == 16);
            @(negedge clk);
            if (c == 16) chk("full_vs", wr_ready, 0);
            step();
        end
        wr_valid = 1'b0;
        sync_vsync = 1'b0;
        @(negedge clk);
        chk("full_keep", fifo_full_seen, 1);
        step();
        rd_req = 1'b0;
        repeat (18) step();
        @(negedge clk);
        chk("drained", mem_en, 0);
        step();

        // reset with 8 entries pending
        rd_req = 1'b1;
        for (int c = 0; c < 8; c++) begin
            wr_valid = 1'b1;
            wr_data  = 12'h700 + 12'(c);
            step();
        end
        wr_valid = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        chk("mrst_en", mem_en, 0);
        chk("mrst_we", mem_we, 0);
        chk("mrst_rdy", wr_ready, 1);
        chk("mrst_addr", mem_addr, 0);
        step();
        step();
        rstn = 1'b1;
        rd_req = 1'b0;
        nb = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_en) nb++;
            step();
        end
        chk("post_rst_idle", nb, 0);
        wr_valid = 1'b1;
        wr_sof   = 1'b1;
        wr_data  = 12'hABC;
        @(negedge clk);
        chk("sof_nobypass", mem_en, 0);
        step();
        wr_valid = 1'b0;
        wr_sof   = 1'b0;
        @(negedge clk);
        chk("sof_we", mem_we, 1);
        chk("sof_addr", mem_addr, 0);
        chk("sof_data", mem_wdata, 12'hABC);
        step();
        rd_req = 1'b1;
        @(negedge clk);
        chk("rd_after_rst", mem_addr, 0);
        step();
        rd_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
